dac_axis_fanout: RTL
====================

# dac_axis_fanout

Downstream buffer and broadcaster between the DAC test-pattern source and the eight RF-DAC AXI-Stream slave ports (s00, s01, s02, s03, s10, s11, s12, s13). It absorbs 128-bit sample words (8 × 16-bit two's-complement samples) from a valid-only source into a FIFO. Each word is presented once to all eight channels. A word retires only after every channel has accepted it, so each channel keeps independent AXI-Stream handshake semantics.

## Interface
Parameters:
- DEPTH, 16, FIFO depth in words; power of two, ≥ 4.
- LEVEL_W, 5, width of fifo_level; must equal log2(DEPTH)+1.

Ports:
- dac_axi_clk  in  1  the single clock; all logic is rising-edge.
- RESET  in  1  synchronous, active-high reset.
- in_tdata  in  128  input sample word; sample 0 in [15:0].
- in_tvalid  in  1  qualifies in_tdata; the source has no backpressure.
- m_tdata  out  128  word broadcast to all eight channels.
- m_tvalid  out  8  per-channel valid; bit order [0..7] = s00, s01, s02, s03, s10, s11, s12, s13.
- m_tready  in  8  per-channel ready, same bit order.
- fifo_level  out  LEVEL_W  current FIFO occupancy; excludes the output slot.
- overflow  out  1  sticky; set when a word is dropped.
- underflow  out  1  one-cycle pulse per starved cycle.
- ovf_count  out  16  dropped-word count (see Configuration).
- udf_count  out  16  starved-cycle count (see Configuration).

## Operation
- **FIFO write.** A write occurs on in_tvalid when the FIFO is not full, or when it is full and a pop occurs in the same cycle. Otherwise the word is dropped and overflow is set. overflow clears only on RESET.
- **Output slot.**
  - One register holds m_tdata, a slot_valid flag and taken[7:0].
  - m_tvalid[i] = slot_valid & ~taken[i].
  - A handshake on channel i (m_tvalid[i] & m_tready[i]) sets taken[i].
- **Retire.** The slot retires in the cycle where taken | (m_tvalid & m_tready) == 8'hFF.
  - On retire, if the FIFO is non-empty, the head is popped into the slot in the same edge, taken is cleared, and slot_valid stays 1. This allows full rate: one word per cycle when all ready bits are high.
  - On retire with an empty FIFO, slot_valid goes to 0.
- **Slot fill.** When slot_valid is 0 and the FIFO is non-empty, the head is popped into the slot on the next edge.
- **Data stability.** m_tdata and the set of still-pending m_tvalid bits are stable while pending (AXI-Stream rule). m_tvalid never depends combinationally on m_tready.
- **Priming.** A primed flag sets on the first accepted write after reset.
- **Underflow.** underflow pulses in every cycle in which primed = 1, slot_valid = 0 and the FIFO is empty. Underflow is not reported before the first word is accepted.
- **Pointers.** Read and write pointers are log2(DEPTH)+1 bits and wrap naturally. full means the MSBs differ and the remaining bits are equal.

## Timing
- **Reset values.** On RESET, one edge clears everything: m_tdata = 0, m_tvalid = 0, fifo_level = 0, overflow = 0, underflow = 0, counters = 0, primed = 0, pointers = 0, taken = 0.
- **Reset mid-operation.** Buffered words are discarded without output.
- **Latency.** Empty FIFO, empty slot, word sampled at edge k: fifo_level = 1 after edge k, then m_tvalid = 8'hFF and fifo_level = 0 after edge k+1.
- **fifo_level** is registered and reflects the write and pop of the preceding edge.
- **Full with write and pop in the same cycle.** The write is accepted, fifo_level stays at DEPTH, and overflow is not set.
- **Stalled channel.** A channel with m_tready held low blocks retirement indefinitely. Other channels show m_tvalid = 0 after their own acceptance. The FIFO then fills and drops further words.

## Configuration
- DAC_FANOUT_STATS_EN.
  - **Defined:** ovf_count increments per dropped word and udf_count per underflow cycle. Both are 16-bit saturating at 16'hFFFF and clear on RESET.
  - **Undefined:** both ports are tied to 0 and no counter logic is built.
  - overflow and underflow behave identically either way.

## Test plan
- **Latency and reset values.** Hold RESET, then write 0x7FFF×8 with m_tready = 8'hFF. Expect all outputs 0 during reset, and m_tvalid = 8'hFF with m_tdata = {8{16'h7FFF}} two edges after the write.
- **Full rate.** Stream 32 incrementing words every cycle with m_tready = 8'hFF. Expect all 32 delivered in order, one per cycle; fifo_level ≤ 1; overflow = 0; underflow = 0 until the stream ends, then a pulse every cycle.
- **Skewed ready.** Write one word, then raise m_tready one bit per cycle starting at bit 0. Expect m_tvalid to fall bit by bit (8'hFE, 8'hFC, …). The slot retires on the 8th handshake, and the next word appears the following cycle.
- **Overflow.** With m_tready = 0, write DEPTH+3 = 19 words. Expect fifo_level = 16, overflow = 1, ovf_count = 2 with STATS_EN (1 word sits in the slot, 16 in the FIFO, 2 dropped). Then release ready and expect exactly 17 words delivered in order.
- **Full with simultaneous write and pop.** With FIFO full, complete a retire in the same cycle as a write. Expect fifo_level to stay at 16 and overflow unchanged.
- **Reset mid-stream.** Assert RESET with 5 words buffered. Expect fifo_level = 0 and m_tvalid = 0 the next cycle, no underflow pulse until a new write, and udf_count = 0.

Source files
------------

// File: rtl/dac_axis_fanout.sv
// Buffers 128-bit DAC sample words from a valid-only source and broadcasts each word to eight
// AXI-Stream channels. Define DAC_FANOUT_STATS_EN to build the saturating drop/starve counters.
module dac_axis_fanout #(
    parameter int DEPTH   = 16,
    parameter int LEVEL_W = 5
) (
    input  logic                dac_axi_clk,
    input  logic                RESET,
    input  logic [127:0]        in_tdata,
    input  logic                in_tvalid,
    output logic [127:0]        m_tdata,
    output logic [7:0]          m_tvalid,
    input  logic [7:0]          m_tready,
    output logic [LEVEL_W-1:0]  fifo_level,
    output logic                overflow,
    output logic                underflow,
    output logic [15:0]         ovf_count,
    output logic [15:0]         udf_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [127:0]       mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr_nxt;
    logic [PW-1:0]      rd_ptr_nxt;
    logic [PW-1:0]      occupancy_nxt;
    logic [LEVEL_W-1:0] level_q;

    logic [127:0]       slot_data;
    logic               slot_valid;
    logic [7:0]         taken;
    logic               overflow_q;
    logic               primed;

    logic               fifo_empty;
    logic               fifo_full;
    logic [7:0]         handshake;
    logic               retire;
    logic               pop;
    logic               wr_en;
    logic               drop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign m_tvalid  = {8{slot_valid}} & ~taken;
    assign handshake = m_tvalid & m_tready;
    assign retire    = slot_valid && ((taken | handshake) == 8'hFF);

    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign pop   = !fifo_empty && (!slot_valid || retire);
    assign wr_en = in_tvalid && (!fifo_full || pop);
    assign drop  = in_tvalid && !wr_en;

    always_comb begin
        wr_ptr_nxt    = wr_ptr + {{AW{1'b0}}, wr_en};
        rd_ptr_nxt    = rd_ptr + {{AW{1'b0}}, pop};
        occupancy_nxt = wr_ptr_nxt - rd_ptr_nxt;
    end

    // NOTE: the storage array has no reset; the pointers alone define which entries are live.
    always_ff @(posedge dac_axi_clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= in_tdata;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge dac_axi_clk) begin
        if (RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            primed     <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            level_q <= LEVEL_W'(occupancy_nxt);
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (wr_en) begin
                primed <= 1'b1;
            end
        end
    end

    // The head is read combinationally, so a pop and a write to the same entry on one edge are safe.
    always_ff @(posedge dac_axi_clk) begin
        if (RESET) begin
            slot_data  <= '0;
            slot_valid <= 1'b0;
            taken      <= '0;
        end else if (pop) begin
            slot_data  <= mem[rd_ptr[AW-1:0]];
            slot_valid <= 1'b1;
            taken      <= '0;
        end else if (retire) begin
            slot_valid <= 1'b0;
            taken      <= '0;
        end else begin
            taken <= taken | handshake;
        end
    end

    assign m_tdata    = slot_data;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign underflow  = primed && !slot_valid && fifo_empty;

`ifdef DAC_FANOUT_STATS_EN
    logic [15:0] ovf_cnt_q;
    logic [15:0] udf_cnt_q;

    always_ff @(posedge dac_axi_clk) begin
        if (RESET) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            if (drop && (ovf_cnt_q != 16'hFFFF)) begin
                ovf_cnt_q <= ovf_cnt_q + 16'd1;
            end
            if (underflow && (udf_cnt_q != 16'hFFFF)) begin
                udf_cnt_q <= udf_cnt_q + 16'd1;
            end
        end
    end

    assign ovf_count = ovf_cnt_q;
    assign udf_count = udf_cnt_q;
`else
    assign ovf_count = '0;
    assign udf_count = '0;
`endif

endmodule
